// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline stages.
package mips_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/imem_rom.sv
// Instruction memory: word array with a combinational read port.
module imem_rom
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int IW         = $clog2(IMEM_DEPTH)
) (
  input  logic [IW-1:0]      addr_i,
  output logic [INSTR_W-1:0] data_o
);
  // Contents are loaded by the environment; no reset clear.
  logic [INSTR_W-1:0] Instr_Mem [0:IMEM_DEPTH-1];

  assign data_o = Instr_Mem[addr_i];
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register,
// sticky fault flag and committed-fetch counter.
module if_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  output logic [INSTR_W-1:0]  if_id_instr_o,
  output logic [31:0]         if_id_pc4_o,
  output logic                if_id_valid_o,
  output logic [31:0]         pc_o,
  output logic                fault_o,
  output logic [31:0]         fetch_cnt_o
);
  localparam int IW = $clog2(IMEM_DEPTH);

  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] fetch_word;
  logic [31:0]        pc_plus4;
  logic               oob;

  imem_rom #(.IMEM_DEPTH(IMEM_DEPTH), .IW(IW)) u_imem (
    .addr_i (pc_q[IW+1:2]),
    .data_o (rom_data)
  );

  assign oob        = (pc_q[31:IW+2] != '0);
  assign fetch_word = oob ? NOP_INSTR : rom_data;
  assign pc_plus4   = pc_q + PC_STEP;

  // Control priority per edge: redirect (flush + load target) beats stall
  // (hold everything), which beats a normal fetch that commits into IF/ID.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) fault_d = 1'b1;
    end else if (!stall_i) begin
      pc_d    = pc_plus4;
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
      if (oob) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign fault_o       = fault_q;
  assign fetch_cnt_o   = cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 16-word instruction memory.
module tb_if_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [31:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;

  if_stage #(.IMEM_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_valid_o (if_id_valid_o),
    .pc_o          (pc_o),
    .fault_o       (fault_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Word i holds 32'hA000_0000 + i, so expected instructions are hand-derivable.
  function automatic logic [31:0] word(input int i);
    return 32'hA000_0000 + i;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_i = 1'b0;
    #1 rst_i = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) dut.u_imem.Instr_Mem[i] = word(i);
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_o, 32'h0); end
    checks++; if (if_id_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", if_id_instr_o); end
    checks++; if (if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h exp 0", if_id_pc4_o); end
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_id_valid_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b exp 0", fault_o); end
    checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", fetch_cnt_o); end
    step();
    rst_i = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (if_id_instr_o !== word(k-1)) begin errors++; $display("FAIL seq_instr%0d: got %h exp %h", k, if_id_instr_o, word(k-1)); end
      checks++; if (if_id_pc4_o !== 32'(4*k)) begin errors++; $display("FAIL seq_pc4%0d: got %h exp %h", k, if_id_pc4_o, 32'(4*k)); end
      checks++; if (if_id_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b exp 1", k, if_id_valid_o); end
    end
    checks++; if (fetch_cnt_o !== 32'd4) begin errors++; $display("FAIL seq_cnt: got %0d exp 4", fetch_cnt_o); end
    checks++; if (pc_o !== 32'd16) begin errors++; $display("FAIL seq_pc: got %h exp 10", pc_o); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (if_id_instr_o !== word(1)) begin errors++; $display("FAIL stall_instr%0d: got %h exp %h", k, if_id_instr_o, word(1)); end
      checks++; if (pc_o !== 32'd8) begin errors++; $display("FAIL stall_pc%0d: got %h exp 8", k, pc_o); end
      checks++; if (fetch_cnt_o !== 32'd2) begin errors++; $display("FAIL stall_cnt%0d: got %0d exp 2", k, fetch_cnt_o); end
    end
    stall_i = 1'b0;
    step();
    checks++; if (if_id_instr_o !== word(2)) begin errors++; $display("FAIL stall_resume_instr: got %h exp %h", if_id_instr_o, word(2)); end
    checks++; if (fetch_cnt_o !== 32'd3) begin errors++; $display("FAIL stall_resume_cnt: got %0d exp 3", fetch_cnt_o); end
  endtask

  task automatic test_redirect_over_stall();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", if_id_valid_o); end
    checks++; if (if_id_instr_o !== 32'h0) begin errors++; $display("FAIL redir_instr: got %h exp 0", if_id_instr_o); end
    checks++; if (if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL redir_pc4: got %h exp 0", if_id_pc4_o); end
    checks++; if (pc_o !== 32'h20) begin errors++; $display("FAIL redir_pc: got %h exp 20", pc_o); end
    checks++; if (fetch_cnt_o !== 32'd3) begin errors++; $display("FAIL redir_cnt: got %0d exp 3", fetch_cnt_o); end
    step();
    checks++; if (if_id_instr_o !== word(8)) begin errors++; $display("FAIL redir_next_instr: got %h exp %h", if_id_instr_o, word(8)); end
    checks++; if (if_id_pc4_o !== 32'h24) begin errors++; $display("FAIL redir_next_pc4: got %h exp 24", if_id_pc4_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL redir_no_fault: got %b exp 0", fault_o); end
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_pc_i = 32'h13;
    step();
    redirect_i = 1'b0;
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL mis_pc: got %h exp 10", pc_o); end
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b exp 1", fault_o); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (if_id_instr_o !== word(4+k)) begin errors++; $display("FAIL mis_instr%0d: got %h exp %h", k, if_id_instr_o, word(4+k)); end
      checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL mis_sticky%0d: got %b exp 1", k, fault_o); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL oob_fault_cleared: got %b exp 0", fault_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h38;
    step();
    redirect_i = 1'b0;
    step(); step();
    checks++; if (if_id_instr_o !== word(15)) begin errors++; $display("FAIL oob_last_instr: got %h exp %h", if_id_instr_o, word(15)); end
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL oob_pc40: got %h exp 40", pc_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL oob_fault_early: got %b exp 0", fault_o); end
    step();
    checks++; if (if_id_instr_o !== 32'h0) begin errors++; $display("FAIL oob_instr: got %h exp 0", if_id_instr_o); end
    checks++; if (if_id_valid_o !== 1'b1) begin errors++; $display("FAIL oob_valid: got %b exp 1", if_id_valid_o); end
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL oob_fault: got %b exp 1", fault_o); end
    checks++; if (pc_o !== 32'h44) begin errors++; $display("FAIL oob_pc44: got %h exp 44", pc_o); end
    step();
    checks++; if (pc_o !== 32'h48) begin errors++; $display("FAIL oob_pc48: got %h exp 48", pc_o); end
  endtask

  task automatic test_pc_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", pc_o); end
    checks++; if (if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h exp 0", if_id_pc4_o); end
    step();
    checks++; if (if_id_instr_o !== word(0)) begin errors++; $display("FAIL wrap_instr: got %h exp %h", if_id_instr_o, word(0)); end
  endtask

  task automatic test_async_reset();
    step(); step();
    stall_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL async_pc: got %h exp 0", pc_o); end
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid: got %b exp 0", if_id_valid_o); end
    checks++; if (if_id_instr_o !== 32'h0) begin errors++; $display("FAIL async_instr: got %h exp 0", if_id_instr_o); end
    checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL async_cnt: got %0d exp 0", fetch_cnt_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL async_fault: got %b exp 0", fault_o); end
    stall_i = 1'b0;
    rst_i = 1'b1;
    step();
    checks++; if (if_id_instr_o !== word(0)) begin errors++; $display("FAIL async_restart_instr: got %h exp %h", if_id_instr_o, word(0)); end
    checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL async_restart_pc: got %h exp 4", pc_o); end
    checks++; if (fetch_cnt_o !== 32'd1) begin errors++; $display("FAIL async_restart_cnt: got %0d exp 1", fetch_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_over_stall();
    test_misaligned();
    test_out_of_range();
    test_pc_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
